banked_register_file: RTL and testbench
=======================================

# banked_register_file

Parametrised 16-bit register-pair file for the SM83 core: replaces the fixed BC/DE/HL register set with PAIRS byte-addressable pairs and NRD synchronous read ports (BRAM-style, 1-cycle latency). Adds a shadow bank plus a sequential context engine that saves or restores the whole active bank for interrupt entry and exit. Sits beside the datapath; the decoder drives its ports directly.

## Interface
- PAIRS, 4, number of 16-bit pairs, ≥2; AW = $clog2(PAIRS)
- NRD, 2, number of read ports, ≥1
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write request
- wr_ready  out  1  write accepted when wr_en && wr_ready; equals !ctx_busy
- wr_addr  in  AW  pair index
- wr_be  in  2  byte enables: [1] high byte (B/D/H), [0] low byte (C/E/L)
- wr_data  in  16  write data
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  port i at [i*AW +: AW]
- rd_data  out  NRD*16  port i at [i*16 +: 16], registered
- ctx_req  in  1  start context operation, sampled in IDLE only
- ctx_op  in  1  0 = save (active→shadow), 1 = restore (shadow→active)
- ctx_busy  out  1  engine active
- ctx_done  out  1  one-cycle completion pulse

## Operation
- Storage: active[PAIRS], shadow[PAIRS], 16 bits each. Reset clears both banks, rd_data, FSM→IDLE, ctx_busy=0, ctx_done=0; wr_ready=1 after reset.
- Write: on accepted write, active[wr_addr] bytes with wr_be set take wr_data; other byte unchanged. wr_be=00 is a no-op. wr_addr ≥ PAIRS is ignored.
- Read: port i with rd_en[i]=1 registers active[rd_addr_i]; rd_en[i]=0 holds rd_data_i. Out-of-range address returns 0. All ports are independent; any ports may read the same pair.
- FSM IDLE→COPY→DONE→IDLE:
  - IDLE: ctx_req=1 latches ctx_op, idx←0, →COPY.
  - COPY: copies pair idx (save: shadow[idx]←active[idx]; restore: active[idx]←shadow[idx]); idx increments; at idx=PAIRS-1 →DONE.
  - DONE: ctx_done=1, →IDLE.
- ctx_busy=1 in COPY and DONE. ctx_req is ignored outside IDLE.
- External writes during busy are refused (wr_ready=0). The requester holds wr_en until it is accepted.
- Reads stay live during busy and return active-bank contents. During restore, pairs not yet copied return their old values.
- Restore copies count as writes to active for the bypass rule (Configuration).

## Timing
- Read latency 1: address at edge N, data valid after edge N.
- Context operation: ctx_req sampled at edge N; COPY occupies cycles N+1..N+PAIRS; ctx_done is high in cycle N+PAIRS+1; IDLE with wr_ready=1 from cycle N+PAIRS+2.
- wr_en with ctx_req in the same IDLE cycle: the write is accepted. A save then captures the new value.
- Reset asserted mid-operation: immediate abort, both banks zero, no ctx_done pulse.

## Configuration
- REGFILE_BYPASS_EN defined: a read at edge N of the pair written at edge N returns the post-write value, byte-merged per enables. This covers external writes and restore copies.
- Undefined: read-before-write; the read returns the pre-write value. No other behaviour changes.

## Test plan
- Reset, then read all pairs on all ports → every rd_data = 0x0000, wr_ready=1, ctx_busy=0.
- Write pair 2 = 0xBEEF with be=11, then be=10 with data 0x12xx → pair 2 reads 0x12EF one cycle after the read request.
- Same-cycle write pair 1 = 0x5A5A and read pair 1 on port 0 → 0x5A5A with REGFILE_BYPASS_EN, old value without it.
- Fill pairs 0..3 with 0x1111..0x4444, save, overwrite all with 0xFFFF, restore → ctx_busy high 5 cycles each op, single ctx_done pulse each, pairs read 0x1111..0x4444.
- wr_en held during save on pair 0 → write accepted only in the cycle after ctx_done; shadow holds the pre-write value.
- Assert rst in COPY cycle 2 of a save → both banks zero, ctx_busy=0 immediately, no ctx_done pulse.

Source files
------------

// File: rtl/banked_register_file.sv
// banked_register_file: PAIRS x 16-bit byte-writable register pairs with NRD
// registered read ports, a shadow bank and a sequential save/restore engine.
// Ports: clk, rst (async, active-high)
//   write : wr_en, wr_ready, wr_addr, wr_be, wr_data
//   read  : rd_en, rd_addr, rd_data (1-cycle latency, holds when not enabled)
//   ctx   : ctx_req, ctx_op (0 save, 1 restore), ctx_busy, ctx_done
// Option: define REGFILE_BYPASS_EN so a read returns the value written on the
//   same edge (external writes and restore copies); otherwise read-before-write.
module banked_register_file #(
    parameter int  PAIRS = 4,
    parameter int  NRD   = 2,
    localparam int AW    = $clog2(PAIRS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [1:0]        wr_be,
    input  logic [15:0]       wr_data,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*16-1:0] rd_data,
    input  logic              ctx_req,
    input  logic              ctx_op,
    output logic              ctx_busy,
    output logic              ctx_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COPY,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] idx;
    logic          op_q;

    logic [15:0] active  [PAIRS];
    logic [15:0] shadow  [PAIRS];
    logic [15:0] act_nxt [PAIRS];
    logic [15:0] shd_nxt [PAIRS];
    logic [15:0] rd_src  [NRD];

    logic wr_fire;
    logic copy_save;
    logic copy_rest;

    assign wr_ready  = !ctx_busy;
    assign wr_fire   = wr_en && wr_ready;
    assign copy_save = (state == S_COPY) && !op_q;
    assign copy_rest = (state == S_COPY) && op_q;

    // Next-state of both banks. Writes and restore copies never overlap
    // because external writes are refused while the engine is busy.
    always_comb begin
        for (int p = 0; p < PAIRS; p++) begin
            act_nxt[p] = active[p];
            shd_nxt[p] = shadow[p];
            if (wr_fire && (wr_addr == AW'(p))) begin
                if (wr_be[1]) act_nxt[p][15:8] = wr_data[15:8];
                if (wr_be[0]) act_nxt[p][7:0]  = wr_data[7:0];
            end
            if (copy_rest && (idx == AW'(p)))
                act_nxt[p] = shadow[p];
            if (copy_save && (idx == AW'(p)))
                shd_nxt[p] = active[p];
        end
    end

    // Read mux; addresses with no matching pair return zero.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_src[i] = '0;
            for (int p = 0; p < PAIRS; p++) begin
                if (rd_addr[i*AW +: AW] == AW'(p)) begin
`ifdef REGFILE_BYPASS_EN
                    rd_src[i] = act_nxt[p];
`else
                    rd_src[i] = active[p];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < PAIRS; p++) begin
                active[p] <= '0;
                shadow[p] <= '0;
            end
        end else begin
            for (int p = 0; p < PAIRS; p++) begin
                active[p] <= act_nxt[p];
                shadow[p] <= shd_nxt[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (rd_en[i])
                    rd_data[i*16 +: 16] <= rd_src[i];
            end
        end
    end

    // Context engine: one pair per COPY cycle, then a single DONE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            idx      <= '0;
            op_q     <= 1'b0;
            ctx_busy <= 1'b0;
            ctx_done <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    ctx_done <= 1'b0;
                    if (ctx_req) begin
                        op_q     <= ctx_op;
                        idx      <= '0;
                        ctx_busy <= 1'b1;
                        state    <= S_COPY;
                    end
                end
                S_COPY: begin
                    idx <= idx + AW'(1);
                    if (idx == AW'(PAIRS - 1)) begin
                        ctx_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    ctx_done <= 1'b0;
                    ctx_busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    ctx_done <= 1'b0;
                    ctx_busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_register_file.sv
// tb_banked_register_file: directed stimulus with a read-data scoreboard
// and direct checks of the write/context handshake signals.
module tb_banked_register_file;

    localparam int PAIRS = 4;
    localparam int NRD   = 2;
    localparam int AW    = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic              wr_ready;
    logic [AW-1:0]     wr_addr;
    logic [1:0]        wr_be;
    logic [15:0]       wr_data;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*16-1:0] rd_data;
    logic              ctx_req;
    logic              ctx_op;
    logic              ctx_busy;
    logic              ctx_done;

    banked_register_file #(.PAIRS(PAIRS), .NRD(NRD)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_be(wr_be), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .ctx_req(ctx_req), .ctx_op(ctx_op),
        .ctx_busy(ctx_busy), .ctx_done(ctx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  port;
        logic [15:0] val;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [15:0] BYP_EXP = 16'h5A5A;
`else
    localparam logic [15:0] BYP_EXP = 16'h0000;
`endif

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Monitor: every enabled read port presents data after the edge.
    always @(posedge clk) begin
        logic [NRD-1:0] en_s;
        exp_t           e;
        en_s = rd_en;
        #1;
        for (int i = 0; i < NRD; i++) begin
            if (en_s[i]) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty port=%0d got=%h want=none",
                             i, rd_data[i*16 +: 16]);
                end else begin
                    e = sbq.pop_front();
                    chk($sformatf("rd_p%0d_tag%0d", i, e.port),
                        rd_data[i*16 +: 16], e.val);
                end
            end
        end
    end

    task automatic idle_in();
        wr_en   = 1'b0;
        wr_be   = 2'b00;
        rd_en   = '0;
        ctx_req = 1'b0;
    endtask

    task automatic cyc();
        @(negedge clk);
        idle_in();
    endtask

    task automatic set_wr(input int a, input logic [1:0] be,
                          input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_be   = be;
        wr_data = d;
    endtask

    task automatic set_rd(input int port, input int a,
                          input logic [15:0] exp);
        exp_t e;
        rd_en[port]              = 1'b1;
        rd_addr[port*AW +: AW]   = AW'(a);
        e.port = 8'(port);
        e.val  = exp;
        sbq.push_back(e);
    endtask

    // Issue a context op, watch busy/done for 10 cycles, and read pair 3
    // during the first COPY cycle (not yet copied, so exp3 is its old value).
    task automatic ctx_run(input logic op, input logic [15:0] exp3,
                           input string nm);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        ctx_req = 1'b1;
        ctx_op  = op;
        cyc();
        for (int k = 0; k < 10; k++) begin
            if (ctx_busy) busy_n++;
            if (ctx_done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k == 0) set_rd(0, 3, exp3);
            cyc();
        end
        chk({nm, "_busy_cycles"}, 16'(busy_n), 16'd5);
        chk({nm, "_done_pulses"}, 16'(done_n), 16'd1);
        chk({nm, "_done_at"}, 16'(done_at), 16'd4);
    endtask

    initial begin
        int acc_at;
        int done_at;
        int done_n;
        logic [15:0] fill [4];
        fill[0] = 16'h1111;
        fill[1] = 16'h2222;
        fill[2] = 16'h3333;
        fill[3] = 16'h4444;

        rst     = 1'b1;
        ctx_op  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        idle_in();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        chk("rst_wr_ready", 16'(wr_ready), 16'd1);
        chk("rst_busy", 16'(ctx_busy), 16'd0);
        chk("rst_done", 16'(ctx_done), 16'd0);
        chk("rst_rd0", rd_data[15:0], 16'h0000);
        chk("rst_rd1", rd_data[31:16], 16'h0000);
        for (int p = 0; p < PAIRS; p++) begin
            set_rd(0, p, 16'h0000);
            set_rd(1, PAIRS - 1 - p, 16'h0000);
            cyc();
        end

        // Byte-enable merge
        set_wr(2, 2'b11, 16'hBEEF);
        cyc();
        set_wr(2, 2'b10, 16'h12AB);
        cyc();
        set_rd(1, 2, 16'h12EF);
        cyc();

        // Same-edge write and read of pair 1
        set_wr(1, 2'b11, 16'h5A5A);
        set_rd(0, 1, BYP_EXP);
        cyc();
        set_rd(0, 1, 16'h5A5A);
        cyc();
        set_wr(1, 2'b00, 16'hFFFF);
        cyc();
        set_rd(0, 1, 16'h5A5A);
        cyc();

        // Save / overwrite / restore
        for (int p = 0; p < PAIRS; p++) begin
            set_wr(p, 2'b11, fill[p]);
            cyc();
        end
        ctx_run(1'b0, 16'h4444, "save1");
        for (int p = 0; p < PAIRS; p++) begin
            set_wr(p, 2'b11, 16'hFFFF);
            cyc();
        end
        set_rd(1, 0, 16'hFFFF);
        cyc();
        ctx_run(1'b1, 16'hFFFF, "rest1");
        for (int p = 0; p < PAIRS; p++) begin
            set_rd(0, p, fill[p]);
            set_rd(1, PAIRS - 1 - p, fill[PAIRS - 1 - p]);
            cyc();
        end

        // Write held during a save is accepted after ctx_done
        ctx_req = 1'b1;
        ctx_op  = 1'b0;
        cyc();
        acc_at  = -1;
        done_at = -1;
        for (int k = 0; k < 12; k++) begin
            if (ctx_done && done_at < 0) done_at = k;
            set_wr(0, 2'b11, 16'hABCD);
            if (wr_ready) begin
                acc_at = k;
                cyc();
                break;
            end
            cyc();
        end
        chk("held_done_at", 16'(done_at), 16'd4);
        chk("held_accept_at", 16'(acc_at), 16'd5);
        set_rd(0, 0, 16'hABCD);
        cyc();
        ctx_run(1'b1, 16'h4444, "rest2");
        set_rd(0, 0, 16'h1111);
        cyc();

        // Write in the same cycle as a save request is captured
        set_wr(1, 2'b11, 16'h7777);
        ctx_run(1'b0, 16'h4444, "save3");
        set_wr(1, 2'b11, 16'h0000);
        cyc();
        set_rd(1, 1, 16'h0000);
        cyc();
        ctx_run(1'b1, 16'h4444, "rest3");
        set_rd(1, 1, 16'h7777);
        cyc();

        // Reset during COPY cycle 2 of a save
        ctx_req = 1'b1;
        ctx_op  = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("abort_busy", 16'(ctx_busy), 16'd0);
        chk("abort_wr_ready", 16'(wr_ready), 16'd1);
        chk("abort_rd1", rd_data[31:16], 16'h0000);
        done_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ctx_done) done_n++;
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (ctx_done) done_n++;
        end
        chk("abort_no_done", 16'(done_n), 16'd0);
        for (int p = 0; p < PAIRS; p++) begin
            set_rd(0, p, 16'h0000);
            cyc();
        end
        ctx_run(1'b1, 16'h0000, "rest4");
        for (int p = 0; p < PAIRS; p++) begin
            set_rd(1, p, 16'h0000);
            cyc();
        end

        cyc();
        chk("sb_drain", 16'(sbq.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
